// File: rtl/score_bcd_scanner_if.sv
// Bus between the score source and the BCD converter / 7-segment scanner.
// Load/busy/done handshake, latched result and display drive lines.
interface score_bcd_scanner_if #(
    parameter int BIN_W  = 15,
    parameter int DIGITS = 4
);
    logic                  load;
    logic [BIN_W-1:0]      binary;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  overflow;
    logic [DIGITS-1:0]     seg_com;
    logic [7:0]            seg_data;

    modport master (
        output load, binary,
        input  busy, done, bcd, overflow, seg_com, seg_data
    );

    modport slave (
        input  load, binary,
        output busy, done, bcd, overflow, seg_com, seg_data
    );
endinterface

// File: rtl/score_bcd_scanner.sv
// Sequential shift-add-3 binary-to-BCD converter with a multiplexed 7-segment scanner.
// Optional macro LEAD_ZERO_BLANK_EN blanks leading zero digits above digit 0.
module score_bcd_scanner #(
    parameter int BIN_W    = 15,
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1
) (
    input logic                clk,
    input logic                rst_n,
    score_bcd_scanner_if.slave bus
);
    localparam int BW    = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int SC_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [BW-1:0] ALL_NINES = {DIGITS{4'h9}};

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t            state_q, state_d;
    logic [BIN_W-1:0]  shift_q, shift_d;
    logic [BW-1:0]     work_q, work_d;
    logic              sticky_q, sticky_d;
    logic [CNT_W-1:0]  bitCnt_q, bitCnt_d;
    logic [BW-1:0]     bcd_q, bcd_d;
    logic              overflow_q, overflow_d;
    logic [SC_W-1:0]   scanCnt_q, scanCnt_d;
    logic [IDX_W-1:0]  scanIdx_q, scanIdx_d;
    logic [DIGITS-1:0] segCom_q, segCom_d;
    logic [7:0]        segData_q, segData_d;

    logic [BW-1:0]     adj;
    logic [BW-1:0]     workShift;
    logic              shiftOut;
    logic [3:0]        curDigit;

    function automatic logic [7:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    glyph = 8'h3F;
            4'd1:    glyph = 8'h06;
            4'd2:    glyph = 8'h5B;
            4'd3:    glyph = 8'h4F;
            4'd4:    glyph = 8'h66;
            4'd5:    glyph = 8'h6D;
            4'd6:    glyph = 8'h7D;
            4'd7:    glyph = 8'h07;
            4'd8:    glyph = 8'h7F;
            4'd9:    glyph = 8'h6F;
            default: glyph = 8'h00;
        endcase
    endfunction

    // One double-dabble step; any bit leaving the top digit means the value needs more digits.
    always_comb begin
        adj = work_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (work_q[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = work_q[4*k +: 4] + 4'd3;
            end
        end
        shiftOut  = adj[BW-1];
        workShift = {adj[BW-2:0], shift_q[BIN_W-1]};
    end

    // Result is latched on the edge entering DONE so it is valid alongside the done pulse.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        work_d     = work_q;
        sticky_d   = sticky_q;
        bitCnt_d   = bitCnt_q;
        bcd_d      = bcd_q;
        overflow_d = overflow_q;
        case (state_q)
            IDLE: begin
                if (bus.load) begin
                    shift_d  = bus.binary;
                    work_d   = '0;
                    sticky_d = 1'b0;
                    bitCnt_d = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                shift_d  = {shift_q[BIN_W-2:0], 1'b0};
                work_d   = workShift;
                sticky_d = sticky_q | shiftOut;
                bitCnt_d = bitCnt_q + CNT_W'(1);
                if (bitCnt_q == CNT_W'(BIN_W - 1)) begin
                    state_d    = DONE;
                    overflow_d = sticky_d;
                    bcd_d      = sticky_d ? ALL_NINES : workShift;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Display registers follow the next index and next result so select and data never disagree.
    always_comb begin
        scanCnt_d = scanCnt_q + SC_W'(1);
        scanIdx_d = scanIdx_q;
        if (scanCnt_q == SC_W'(SCAN_DIV - 1)) begin
            scanCnt_d = '0;
            scanIdx_d = (scanIdx_q == IDX_W'(DIGITS - 1)) ? '0 : scanIdx_q + IDX_W'(1);
        end
        curDigit = '0;
        segCom_d = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (scanIdx_d == IDX_W'(k)) begin
                curDigit    = bcd_d[4*k +: 4];
                segCom_d[k] = 1'b1;
            end
        end
`ifdef LEAD_ZERO_BLANK_EN
        begin
            logic upperZero;
            logic blankDigit;
            upperZero  = 1'b1;
            blankDigit = 1'b0;
            for (int k = DIGITS - 1; k >= 0; k--) begin
                upperZero = upperZero & (bcd_d[4*k +: 4] == 4'd0);
                if ((scanIdx_d == IDX_W'(k)) && (k > 0)) begin
                    blankDigit = upperZero;
                end
            end
            segData_d = blankDigit ? 8'h00 : glyph(curDigit);
        end
`else
        segData_d = glyph(curDigit);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            work_q     <= '0;
            sticky_q   <= 1'b0;
            bitCnt_q   <= '0;
            bcd_q      <= '0;
            overflow_q <= 1'b0;
            scanCnt_q  <= '0;
            scanIdx_q  <= '0;
            segCom_q   <= DIGITS'(1);
            segData_q  <= 8'h3F;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            work_q     <= work_d;
            sticky_q   <= sticky_d;
            bitCnt_q   <= bitCnt_d;
            bcd_q      <= bcd_d;
            overflow_q <= overflow_d;
            scanCnt_q  <= scanCnt_d;
            scanIdx_q  <= scanIdx_d;
            segCom_q   <= segCom_d;
            segData_q  <= segData_d;
        end
    end

    assign bus.busy     = (state_q == SHIFT);
    assign bus.done     = (state_q == DONE);
    assign bus.bcd      = bcd_q;
    assign bus.overflow = overflow_q;
    assign bus.seg_com  = segCom_q;
    assign bus.seg_data = segData_q;
endmodule

// File: tb/tb_score_bcd_scanner.sv
// Bench for score_bcd_scanner: vector table through a result scoreboard, plus
// handshake, reset-abort, scan-rate and small-parameter sequences.
module tb_score_bcd_scanner;
    logic clk = 1'b0;
    logic rst_n;
    logic rst3_n;

    always #5 clk = ~clk;

    score_bcd_scanner_if #(.BIN_W(15), .DIGITS(4)) mIf ();
    score_bcd_scanner_if #(.BIN_W(15), .DIGITS(4)) sIf ();
    score_bcd_scanner_if #(.BIN_W(8),  .DIGITS(3)) bIf ();

    score_bcd_scanner #(.BIN_W(15), .DIGITS(4), .SCAN_DIV(1)) dutMain (
        .clk(clk), .rst_n(rst_n), .bus(mIf.slave));
    score_bcd_scanner #(.BIN_W(15), .DIGITS(4), .SCAN_DIV(3)) dutScan (
        .clk(clk), .rst_n(rst3_n), .bus(sIf.slave));
    score_bcd_scanner #(.BIN_W(8), .DIGITS(3), .SCAN_DIV(1)) dutSmall (
        .clk(clk), .rst_n(rst3_n), .bus(bIf.slave));

    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
    } expT;

    typedef struct {
        int unsigned value;
        logic [15:0] bcd;
        logic        ovf;
    } vecT;

    int  tests = 0;
    int  fails = 0;
    int  scanEdges;
    expT expQ[$];
    vecT vecs[15];

    // Reference scan position: edges counted since the scan instance left reset.
    always @(posedge clk or negedge rst3_n) begin
        if (!rst3_n) scanEdges <= 0;
        else         scanEdges <= scanEdges + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [7:0] expGlyph(input logic [15:0] v, input int k);
        logic [15:0] tmp;
        logic [3:0]  d;
        tmp = v >> (4 * k);
        d   = tmp[3:0];
`ifdef LEAD_ZERO_BLANK_EN
        if (k > 0 && tmp == 16'h0) return 8'h00;
`endif
        case (d)
            4'd0: return 8'h3F;
            4'd1: return 8'h06;
            4'd2: return 8'h5B;
            4'd3: return 8'h4F;
            4'd4: return 8'h66;
            4'd5: return 8'h6D;
            4'd6: return 8'h7D;
            4'd7: return 8'h07;
            4'd8: return 8'h7F;
            4'd9: return 8'h6F;
            default: return 8'h00;
        endcase
    endfunction

    always @(negedge clk) begin
        if (rst_n && mIf.done) begin
            if (expQ.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL doneWithoutRequest: got done=1, expected no result pending at %0t", $time);
            end else begin
                expT e;
                e = expQ.pop_front();
                checkOutput("bcd", 32'(mIf.bcd), 32'(e.bcd));
                checkOutput("overflow", 32'(mIf.overflow), 32'(e.ovf));
            end
        end
    end

    task automatic applyStimulus(input int unsigned v, input logic [15:0] eb, input logic eo);
        int cycles;
        int busyCnt;
        expT e;
        @(negedge clk);
        mIf.load   = 1'b1;
        mIf.binary = 15'(v);
        e.bcd = eb;
        e.ovf = eo;
        expQ.push_back(e);
        @(negedge clk);
        mIf.load = 1'b0;
        cycles   = 1;
        busyCnt  = 0;
        while (!mIf.done && cycles < 100) begin
            if (mIf.busy) busyCnt++;
            @(negedge clk);
            cycles++;
        end
        checkOutput("latency", 32'(cycles), 32'd16);
        checkOutput("busyCycles", 32'(busyCnt), 32'd15);
        checkOutput("busyInDone", 32'(mIf.busy), 32'd0);
    endtask

    task automatic waitDone();
        int cnt;
        cnt = 0;
        while (!mIf.done && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 100) checkOutput("doneTimeout", 32'(mIf.done), 32'd1);
    endtask

    task automatic checkDisplay(input logic [15:0] eb);
        int k;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            k = 0;
            for (int j = 0; j < 4; j++) if (mIf.seg_com[j]) k = j;
            checkOutput("segComOneHot", 32'($onehot(mIf.seg_com)), 32'd1);
            checkOutput("segData", 32'(mIf.seg_data), 32'(expGlyph(eb, k)));
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0]  = '{0,     16'h0000, 1'b0};
        vecs[1]  = '{1,     16'h0001, 1'b0};
        vecs[2]  = '{7,     16'h0007, 1'b0};
        vecs[3]  = '{9,     16'h0009, 1'b0};
        vecs[4]  = '{10,    16'h0010, 1'b0};
        vecs[5]  = '{99,    16'h0099, 1'b0};
        vecs[6]  = '{100,   16'h0100, 1'b0};
        vecs[7]  = '{999,   16'h0999, 1'b0};
        vecs[8]  = '{1234,  16'h1234, 1'b0};
        vecs[9]  = '{5678,  16'h5678, 1'b0};
        vecs[10] = '{9012,  16'h9012, 1'b0};
        vecs[11] = '{32767, 16'h9999, 1'b1};
        vecs[12] = '{9999,  16'h9999, 1'b0};
        vecs[13] = '{10000, 16'h9999, 1'b1};
        vecs[14] = '{4321,  16'h4321, 1'b0};

        rst_n      = 1'b0;
        rst3_n     = 1'b0;
        mIf.load   = 1'b0;
        mIf.binary = '0;
        sIf.load   = 1'b0;
        sIf.binary = '0;
        bIf.load   = 1'b0;
        bIf.binary = '0;
        repeat (3) @(negedge clk);

        checkOutput("rstBusy",    32'(mIf.busy),     32'd0);
        checkOutput("rstDone",    32'(mIf.done),     32'd0);
        checkOutput("rstBcd",     32'(mIf.bcd),      32'd0);
        checkOutput("rstOvf",     32'(mIf.overflow), 32'd0);
        checkOutput("rstSegCom",  32'(mIf.seg_com),  32'h1);
        checkOutput("rstSegData", 32'(mIf.seg_data), 32'h3F);
        rst_n  = 1'b1;
        rst3_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].value, vecs[i].bcd, vecs[i].ovf);
            checkDisplay(vecs[i].bcd);
        end

        // Load while busy is dropped; the load right after done is accepted.
        @(negedge clk);
        mIf.load   = 1'b1;
        mIf.binary = 15'd42;
        expQ.push_back('{16'h0042, 1'b0});
        @(negedge clk);
        mIf.load = 1'b0;
        repeat (3) @(negedge clk);
        mIf.load   = 1'b1;
        mIf.binary = 15'd7;
        @(negedge clk);
        mIf.load = 1'b0;
        waitDone();
        applyStimulus(7, 16'h0007, 1'b0);

        // Reset in the fifth shift cycle.
        applyStimulus(1234, 16'h1234, 1'b0);
        @(negedge clk);
        mIf.load   = 1'b1;
        mIf.binary = 15'd4321;
        expQ.push_back('{16'h4321, 1'b0});
        @(negedge clk);
        mIf.load = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abortBusy",    32'(mIf.busy),     32'd0);
        checkOutput("abortDone",    32'(mIf.done),     32'd0);
        checkOutput("abortBcd",     32'(mIf.bcd),      32'd0);
        checkOutput("abortOvf",     32'(mIf.overflow), 32'd0);
        checkOutput("abortSegCom",  32'(mIf.seg_com),  32'h1);
        checkOutput("abortSegData", 32'(mIf.seg_data), 32'h3F);
        expQ.delete();
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(500, 16'h0500, 1'b0);

        // Scan rate of three cycles per digit.
        @(negedge clk);
        sIf.load   = 1'b1;
        sIf.binary = 15'd1234;
        @(negedge clk);
        sIf.load = 1'b0;
        begin
            int cnt;
            cnt = 0;
            while (!sIf.done && cnt < 100) begin
                @(negedge clk);
                cnt++;
            end
            checkOutput("scanDone", 32'(sIf.done), 32'd1);
            checkOutput("scanBcd", 32'(sIf.bcd), 32'h1234);
        end
        for (int c = 0; c < 24; c++) begin
            int idx;
            @(negedge clk);
            idx = (scanEdges / 3) % 4;
            checkOutput("scanCom",  32'(sIf.seg_com),  32'(1 << idx));
            checkOutput("scanData", 32'(sIf.seg_data), 32'(expGlyph(16'h1234, idx)));
        end

        // Eight-bit input, three digits.
        for (int t = 0; t < 2; t++) begin
            int          cycles;
            int unsigned v;
            logic [11:0] eb;
            v  = (t == 0) ? 255 : 100;
            eb = (t == 0) ? 12'h255 : 12'h100;
            @(negedge clk);
            bIf.load   = 1'b1;
            bIf.binary = 8'(v);
            @(negedge clk);
            bIf.load = 1'b0;
            cycles   = 1;
            while (!bIf.done && cycles < 100) begin
                @(negedge clk);
                cycles++;
            end
            checkOutput("smallLatency", 32'(cycles),       32'd9);
            checkOutput("smallBcd",     32'(bIf.bcd),      32'(eb));
            checkOutput("smallOvf",     32'(bIf.overflow), 32'd0);
        end

        repeat (3) @(negedge clk);
        checkOutput("queueDrained", 32'(expQ.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
